// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush arbiter for the 5-stage pipeline.
// Resolves ID load-use, EX multi-cycle and MEM wait requests into a per-stage
// hold vector and flush strobes, tracks outstanding data-memory accesses with
// a timeout, and counts cycles in which the PC was held.
module pipe_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 8,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_stall_req_i,
  input  logic             ex_stall_req_i,
  input  logic             mem_access_i,
  input  logic             dmem_ready_i,
  input  logic             branch_redirect_i,
  input  logic             exc_i,
  output logic [5:0]       stall_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             flush_all_o,
  output logic             bus_err_o,
  output logic             mem_wait_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  // Hold vectors: a stall at stage N also holds every stage upstream of it.
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  localparam logic [TO_W-1:0]  WAIT_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Arbitration below the MEM level: EX, then branch redirect, then ID.
  // A redirect squashes the younger instructions, so an ID hold on a
  // wrong-path instruction is simply dropped.
  logic [5:0] low_stall;
  logic       low_flush;

  always_comb begin
    low_stall = STALL_NONE;
    low_flush = 1'b0;
    if (ex_stall_req_i) begin
      low_stall = STALL_EX;
    end else if (branch_redirect_i) begin
      low_flush = 1'b1;
    end else if (id_stall_req_i) begin
      low_stall = STALL_ID;
    end
  end

  // Next-state and combinational outputs; everything quiet while rst is high.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    stall_o       = STALL_NONE;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    flush_all_o   = 1'b0;
    bus_err_o     = 1'b0;
    mem_wait_o    = 1'b0;

    if (!rst) begin
      unique case (state_q)
        ST_RUN: begin
          if (exc_i) begin
            flush_all_o = 1'b1;
          end else if (mem_access_i && !dmem_ready_i) begin
            stall_o    = STALL_MEM;
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = TO_W'(1);
          end else begin
            stall_o       = low_stall;
            flush_if_id_o = low_flush;
            flush_id_ex_o = low_flush;
          end
        end

        ST_MEM_WAIT: begin
          mem_wait_o = 1'b1;
          if (exc_i) begin
            flush_all_o = 1'b1;
            state_d     = ST_RUN;
            wait_cnt_d  = '0;
          end else if (dmem_ready_i) begin
            // Memory answered: MEM hold drops this very cycle and the
            // remaining requesters get the pipeline.
            stall_o       = low_stall;
            flush_if_id_o = low_flush;
            flush_id_ex_o = low_flush;
            state_d       = ST_RUN;
            wait_cnt_d    = '0;
          end else if (wait_cnt_q == WAIT_LIMIT) begin
            bus_err_o   = 1'b1;
            flush_all_o = 1'b1;
            state_d     = ST_RUN;
            wait_cnt_d  = '0;
          end else begin
            stall_o    = STALL_MEM;
            wait_cnt_d = wait_cnt_q + TO_W'(1);
          end
        end

        default: begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      endcase
    end
  end

  // Saturating count of cycles with the PC held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o[0] && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Register boundary: FSM state, wait counter, stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule
